// File: rtl/lc3_bus_pkg.sv
// Shared constants and types for the LC-3 datapath bus arbiter.
package lc3_bus_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  localparam int unsigned SRC_MARMUX = 0;
  localparam int unsigned SRC_PC     = 1;
  localparam int unsigned SRC_ALU    = 2;
  localparam int unsigned SRC_MDR    = 3;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_prio_enc.sv
// Lowest-index priority encoder over a gate bitmask, with any/multi flags.
module onehot_prio_enc #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          multi
);

  logic seen;

  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    seen  = 1'b0;
    // Scan downward so the last hit is the lowest set index.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (seen) begin
          multi = 1'b1;
        end
        seen = 1'b1;
      end
    end
    any = seen;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Registered datapath bus selector with bus-hold, contention detection,
// a latched FAULT state and a saturating contention counter.
module bus_arbiter
  import lc3_bus_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter  int unsigned N_SRC     = 4,
  parameter  int unsigned HOLD_LAST = 1,
  parameter  int unsigned ERR_CNT_W = 8,
  localparam int unsigned OW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       gate,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic                   clr_fault,
  output logic [WIDTH-1:0]       bus,
  output logic                   bus_valid,
  output logic [OW-1:0]          bus_owner,
  output logic                   contention,
  output logic                   fault,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  logic [OW-1:0] enc_idx;
  logic          enc_any;
  logic          enc_multi;

  onehot_prio_enc #(
    .N (N_SRC)
  ) u_enc (
    .mask  (gate),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     bus_q, bus_d;
  logic                 bus_valid_q, bus_valid_d;
  logic [OW-1:0]        bus_owner_q, bus_owner_d;
  logic                 contention_q, contention_d;
  logic                 fault_q, fault_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      bus_q        <= '0;
      bus_valid_q  <= 1'b0;
      bus_owner_q  <= '0;
      contention_q <= 1'b0;
      fault_q      <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bus_q        <= bus_d;
      bus_valid_q  <= bus_valid_d;
      bus_owner_q  <= bus_owner_d;
      contention_q <= contention_d;
      fault_q      <= fault_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus_d        = bus_q;
    bus_valid_d  = 1'b0;
    bus_owner_d  = bus_owner_q;
    contention_d = enc_multi;
    fault_d      = fault_q;
    err_cnt_d    = err_cnt_q;

    // Contention is counted in either state; the counter sticks at all-ones.
    if (enc_multi && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    case (state_q)
      RUN: begin
        if (enc_any) begin
          bus_d       = src_data[int'(enc_idx)*WIDTH +: WIDTH];
          bus_owner_d = enc_idx;
          bus_valid_d = 1'b1;
          if (enc_multi) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end else if (HOLD_LAST == 0) begin
          bus_d = '0;
        end
      end
      FAULT: begin
        bus_d = '0;
        if (clr_fault) begin
          state_d = RUN;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign bus        = bus_q;
  assign bus_valid  = bus_valid_q;
  assign bus_owner  = bus_owner_q;
  assign contention = contention_q;
  assign fault      = fault_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: two arbiter builds (hold/8-bit counter, no-hold/2-bit
// counter) share stimulus; a reference model feeds queues, a monitor checks.
module tb_bus_arbiter;
  import lc3_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  gate = '0;
  logic [63:0] src_data = '0;
  logic        clr_fault = 1'b0;

  logic [15:0] a_bus, b_bus;
  logic        a_valid, b_valid, a_cont, b_cont, a_fault, b_fault;
  logic [1:0]  a_owner, b_owner;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  bus_arbiter #(.WIDTH(16), .N_SRC(4), .HOLD_LAST(1), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .gate(gate), .src_data(src_data), .clr_fault(clr_fault),
    .bus(a_bus), .bus_valid(a_valid), .bus_owner(a_owner),
    .contention(a_cont), .fault(a_fault), .err_cnt(a_cnt));

  bus_arbiter #(.WIDTH(16), .N_SRC(4), .HOLD_LAST(0), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .gate(gate), .src_data(src_data), .clr_fault(clr_fault),
    .bus(b_bus), .bus_valid(b_valid), .bus_owner(b_owner),
    .contention(b_cont), .fault(b_fault), .err_cnt(b_cnt));

  typedef struct {
    int bus;
    int valid;
    int owner;
    int cont;
    int fault;
    int cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad   = 0;

  // Abstract model state per build: index 0 = dut_a, 1 = dut_b.
  int m_bus[2];
  int m_owner[2];
  int m_fault[2];
  int m_cnt[2];
  int m_hold[2] = '{1, 0};
  int m_cmax[2] = '{255, 3};

  function automatic exp_t model_step(input int c, input bit r, input logic [3:0] g,
                                      input bit clr, input logic [63:0] sd);
    exp_t e;
    int n;
    int low;
    n   = $countones(g);
    low = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[i] && low == 0 && !(i > 0 && g[0])) begin
        low = i;
        break;
      end
    end
    e.valid = 0;
    e.cont  = 0;
    if (r) begin
      m_bus[c] = 0; m_owner[c] = 0; m_fault[c] = 0; m_cnt[c] = 0;
    end else begin
      e.cont = (n >= 2) ? 1 : 0;
      if (n >= 2) m_cnt[c] = (m_cnt[c] + 1 > m_cmax[c]) ? m_cmax[c] : m_cnt[c] + 1;
      if (m_fault[c] != 0) begin
        m_bus[c] = 0;
        if (clr) m_fault[c] = 0;
      end else if (n == 0) begin
        if (m_hold[c] == 0) m_bus[c] = 0;
      end else begin
        m_bus[c]   = int'((sd >> (16 * low)) & 64'hFFFF);
        m_owner[c] = low;
        e.valid    = 1;
        if (n >= 2) m_fault[c] = 1;
      end
    end
    e.bus = m_bus[c]; e.owner = m_owner[c]; e.fault = m_fault[c]; e.cnt = m_cnt[c];
    return e;
  endfunction

  task automatic cycle(input bit r, input logic [3:0] g, input bit clr, input logic [63:0] sd);
    @(negedge clk);
    rst = r; gate = g; clr_fault = clr; src_data = sd;
    q_a.push_back(model_step(0, r, g, clr, sd));
    q_b.push_back(model_step(1, r, g, clr, sd));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, so one entry is retired per edge.
  initial begin
    exp_t ea, eb;
    forever begin
      @(posedge clk);
      #2;
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk("a.bus",   int'(a_bus),   ea.bus);
        chk("a.valid", int'(a_valid), ea.valid);
        chk("a.owner", int'(a_owner), ea.owner);
        chk("a.cont",  int'(a_cont),  ea.cont);
        chk("a.fault", int'(a_fault), ea.fault);
        chk("a.cnt",   int'(a_cnt),   ea.cnt);
        chk("b.bus",   int'(b_bus),   eb.bus);
        chk("b.valid", int'(b_valid), eb.valid);
        chk("b.owner", int'(b_owner), eb.owner);
        chk("b.cont",  int'(b_cont),  eb.cont);
        chk("b.fault", int'(b_fault), eb.fault);
        chk("b.cnt",   int'(b_cnt),   eb.cnt);
      end
    end
  end

  function automatic logic [63:0] pack(input int s3, input int s2, input int s1, input int s0);
    return {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
  endfunction

  initial begin
    logic [3:0] g;
    int sel;
    // Reset then idle.
    cycle(1, 4'b0000, 0, '0);
    cycle(1, 4'b0000, 0, '0);
    cycle(0, 4'b0000, 0, '0);
    // Single gates.
    cycle(0, 4'b0010, 0, pack(0, 0, 16'h3000, 0));
    cycle(0, 4'b0100, 0, pack(0, 16'h1234, 0, 0));
    // Hold versus zero when idle.
    cycle(0, 4'b0100, 0, pack(0, 16'hBEEF, 0, 0));
    repeat (3) cycle(0, 4'b0000, 0, pack(1, 2, 3, 4));
    // Contention enters FAULT; gates then ignored.
    cycle(0, 4'b1010, 0, pack(16'h9999, 0, 16'h0042, 16'h7777));
    cycle(0, 4'b0100, 0, pack(0, 16'h4444, 0, 0));
    // clr_fault in RUN has no effect after recovery; recovery ignores that cycle's gate.
    cycle(0, 4'b1000, 1, pack(16'h5555, 0, 0, 0));
    cycle(0, 4'b1000, 0, pack(16'h5555, 0, 0, 0));
    cycle(0, 4'b0001, 1, pack(0, 0, 0, 16'h0101));
    // Saturation: five contention events.
    repeat (5) cycle(0, 4'b0011, 0, pack(0, 0, 16'hAAAA, 16'hBBBB));
    // Contention and clr together in FAULT: clr wins, still counted.
    cycle(0, 4'b0110, 1, pack(0, 1, 2, 3));
    cycle(0, 4'b0000, 0, '0);
    // Reset beats clr_fault and contention.
    cycle(1, 4'b1100, 1, pack(16'h1111, 16'h2222, 0, 0));
    cycle(0, 4'b0000, 0, '0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3)       g = 4'b0000;
      else if (sel < 8)  g = 4'(1 << $urandom_range(0, 3));
      else               g = 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 59) == 0), g, ($urandom_range(0, 3) == 0),
            {$urandom, $urandom});
    end
    cycle(0, 4'b0000, 0, '0);
    for (int i = 0; i < 20 && q_a.size() > 0; i++) @(posedge clk);
    #5;
    total++;
    if (q_a.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q_a.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
